// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: 3-stage integer to (S,E,F) float converter with
// round/truncate, saturation and valid/ready streaming.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake
//   in_d [DW]           two's-complement integer
//   in_rnd              1 = round half up on magnitude, 0 = truncate
//   out_valid/out_ready output handshake
//   out_s, out_e [EW], out_f [FW]  sign, exponent, significand
//   out_sat, out_inexact           status flags
module fpcvt_pipe #(
  parameter int DW = 13,
  parameter int EW = 3,
  parameter int FW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_d,
  input  logic          in_rnd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [FW-1:0] out_f,
  output logic          out_sat,
  output logic          out_inexact
);

  localparam int PW = $clog2(DW);
  localparam int XW = ((PW > EW) ? PW : EW) + 1;

  typedef struct packed {
    logic          s;
    logic [DW-1:0] m;
    logic          rnd;
  } s1_t;

  typedef struct packed {
    logic          s;
    logic [XW-1:0] e;
    logic [FW-1:0] f;
    logic          r;
    logic          st;
    logic          rnd;
  } s2_t;

  logic r_v1;
  logic r_v2;
  logic r_v3;
  s1_t  r_s1;
  s2_t  r_s2;

  logic w_rdy1;
  logic w_rdy2;
  logic w_rdy3;

  assign w_rdy3   = !r_v3 | out_ready;
  assign w_rdy2   = !r_v2 | w_rdy3;
  assign w_rdy1   = !r_v1 | w_rdy2;
  assign in_ready = w_rdy1;
  assign out_valid = r_v3;

  // stage 1: sign and magnitude
  s1_t w_s1;

  always_comb begin
    w_s1     = '0;
    w_s1.s   = in_d[DW-1];
    w_s1.m   = in_d[DW-1] ? -in_d : in_d;
    w_s1.rnd = in_rnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (w_rdy1) begin
      r_v1 <= in_valid;
      if (in_valid)
        r_s1 <= w_s1;
    end
  end

  // stage 2: leading one, field extraction
  logic [PW-1:0] w_p;
  logic          w_nz;
  logic [PW-1:0] w_sh;
  logic [DW-1:0] w_norm;
  logic          w_big;
  s2_t           w_s2;

  always_comb begin
    w_p  = '0;
    w_nz = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (r_s1.m[i]) begin
        w_p  = PW'(i);
        w_nz = 1'b1;
      end
    end
  end

  // left-justify the magnitude so the leading one sits at DW-1
  assign w_sh   = PW'(DW - 1) - w_p;
  assign w_norm = r_s1.m << w_sh;
  assign w_big  = w_nz & (w_p >= PW'(FW));

  always_comb begin
    w_s2     = '0;
    w_s2.s   = r_s1.s;
    w_s2.rnd = r_s1.rnd;
    unique case (1'b1)
      w_big: begin
        w_s2.e  = XW'(w_p) - XW'(FW - 1);
        w_s2.f  = w_norm[DW-1 -: FW];
        w_s2.r  = w_norm[DW-1-FW];
        w_s2.st = |w_norm[DW-2-FW:0];
      end
      default: begin
        w_s2.e  = '0;
        w_s2.f  = r_s1.m[FW-1:0];
        w_s2.r  = 1'b0;
        w_s2.st = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
    end else if (w_rdy2) begin
      r_v2 <= r_v1;
      if (r_v1)
        r_s2 <= w_s2;
    end
  end

  // stage 3: round, renormalise, saturate
  logic          w_inc;
  logic [FW:0]   w_sum;
  logic          w_cy;
  logic [FW-1:0] w_f2;
  logic [XW-1:0] w_e2;
  logic          w_sat;
  logic [EW-1:0] w_eo;
  logic [FW-1:0] w_fo;
  logic          w_inx;

  assign w_inc = r_s2.rnd & r_s2.r;
  assign w_sum = {1'b0, r_s2.f} + {{FW{1'b0}}, w_inc};
  assign w_cy  = w_sum[FW];
  // carry out of F means the significand became 2.0; renormalise
  assign w_f2  = w_cy ? {1'b1, {(FW-1){1'b0}}}
                      : w_sum[FW-1:0];
  assign w_e2  = r_s2.e + {{(XW-1){1'b0}}, w_cy};
  assign w_sat = |w_e2[XW-1:EW];
  assign w_eo  = w_sat ? '1 : w_e2[EW-1:0];
  assign w_fo  = w_sat ? '1 : w_f2;
  assign w_inx = r_s2.r | r_s2.st | w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3        <= 1'b0;
      out_s       <= 1'b0;
      out_e       <= '0;
      out_f       <= '0;
      out_sat     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (w_rdy3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        out_s       <= r_s2.s;
        out_e       <= w_eo;
        out_f       <= w_fo;
        out_sat     <= w_sat;
        out_inexact <= w_inx;
      end
    end
  end

endmodule
